// File: rtl/palette_lut.sv
// rtl/palette_lut.sv - 256-entry xRGB555 palette LUT with CPU port and blank-aligned video pipeline
// Optional brightness fade register is compiled in with `define PALETTE_FADE_EN.
module palette_lut #(
  parameter int PIPE_BLANK = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce_pixel,
  input  logic [7:0]  color_in,
  input  logic        hblank,
  input  logic        vblank,
  input  logic [1:0]  wr,
  input  logic [8:0]  address,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        hblank_out,
  output logic        vblank_out
);

  function automatic logic [7:0] expand5(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction

  // Palette storage as two byte lanes; not reset, behaves as RAM.
  logic [7:0] pal_lo [256];
  logic [7:0] pal_hi [256];
  logic       pal_sel;

  assign pal_sel = ~address[8];

  always_ff @(posedge clk) begin
    if (pal_sel && wr[0]) pal_lo[address[7:0]] <= din[7:0];
    if (pal_sel && wr[1]) pal_hi[address[7:0]] <= din[15:8];
  end

  logic [15:0] ctrl_rd;
  logic [7:0]  r_exp, g_exp, b_exp;
  logic [7:0]  r_col, g_col, b_col;

`ifdef PALETTE_FADE_EN
  logic [4:0] bright_q;
  logic [4:0] bright_d;

  function automatic logic [7:0] fade(input logic [7:0] c, input logic [4:0] b);
    logic [12:0] p;
    p = {5'd0, c} * {8'd0, b};
    return 8'(p >> 4);
  endfunction

  always_comb begin
    bright_d = bright_q;
    if (address[8] && wr[0]) bright_d = (din[4:0] > 5'd16) ? 5'd16 : din[4:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bright_q <= 5'd16;
    else          bright_q <= bright_d;
  end

  assign ctrl_rd = {11'd0, bright_q};
  assign r_col   = fade(r_exp, bright_q);
  assign g_col   = fade(g_exp, bright_q);
  assign b_col   = fade(b_exp, bright_q);
`else
  assign ctrl_rd = 16'h0000;
  assign r_col   = r_exp;
  assign g_col   = g_exp;
  assign b_col   = b_exp;
`endif

  logic [15:0] dout_d, dout_q;

  always_comb begin
    dout_d = ctrl_rd;
    if (pal_sel) dout_d = {pal_hi[address[7:0]], pal_lo[address[7:0]]};
  end

  // S0 state: video read address plus the first PIPE_BLANK-1 blank stages.
  logic [7:0]            addr_q;
  logic [PIPE_BLANK-2:0] hb_q;
  logic [PIPE_BLANK-2:0] vb_q;
  logic [14:0]           vid_word;
  logic                  blank_dly;

  assign vid_word  = {pal_hi[addr_q][6:0], pal_lo[addr_q]};
  assign r_exp     = expand5(vid_word[14:10]);
  assign g_exp     = expand5(vid_word[9:5]);
  assign b_exp     = expand5(vid_word[4:0]);
  assign blank_dly = hb_q[PIPE_BLANK-2] | vb_q[PIPE_BLANK-2];

  logic [7:0] red_d, green_d, blue_d;
  logic [7:0] red_q, green_q, blue_q;
  logic       hbo_q, vbo_q;

  always_comb begin
    red_d   = r_col;
    green_d = g_col;
    blue_d  = b_col;
    if (blank_dly) begin
      red_d   = 8'd0;
      green_d = 8'd0;
      blue_d  = 8'd0;
    end
  end

  // Blank stages reset to 1 so the pipeline emits black until real pixels arrive.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_q  <= 16'h0000;
      addr_q  <= 8'd0;
      hb_q    <= '1;
      vb_q    <= '1;
      red_q   <= 8'd0;
      green_q <= 8'd0;
      blue_q  <= 8'd0;
      hbo_q   <= 1'b1;
      vbo_q   <= 1'b1;
    end else begin
      dout_q <= dout_d;
      if (ce_pixel) begin
        addr_q  <= color_in;
        hb_q[0] <= hblank;
        vb_q[0] <= vblank;
        for (int i = 1; i < PIPE_BLANK - 1; i++) begin
          hb_q[i] <= hb_q[i-1];
          vb_q[i] <= vb_q[i-1];
        end
        red_q   <= red_d;
        green_q <= green_d;
        blue_q  <= blue_d;
        hbo_q   <= hb_q[PIPE_BLANK-2];
        vbo_q   <= vb_q[PIPE_BLANK-2];
      end
    end
  end

  assign dout       = dout_q;
  assign red        = red_q;
  assign green      = green_q;
  assign blue       = blue_q;
  assign hblank_out = hbo_q;
  assign vblank_out = vbo_q;

endmodule

// File: tb/tb_palette_lut.sv
// tb/tb_palette_lut.sv - table-driven bench for palette_lut
// Fade checks are included when PALETTE_FADE_EN is defined.
module tb_palette_lut;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce_pixel = 1'b0;
  logic [7:0]  color_in = 8'd0;
  logic        hblank = 1'b1;
  logic        vblank = 1'b1;
  logic [1:0]  wr = 2'b00;
  logic [8:0]  address = 9'd0;
  logic [15:0] din = 16'd0;
  logic [15:0] dout;
  logic [7:0]  red, green, blue;
  logic        hblank_out, vblank_out;

  int n_pass = 0;
  int n_total = 0;

`ifdef PALETTE_FADE_EN
  localparam logic [15:0] CTRL_RESET = 16'd16;
`else
  localparam logic [15:0] CTRL_RESET = 16'd0;
`endif

  palette_lut #(.PIPE_BLANK(2)) dut (
    .clk(clk), .reset_n(reset_n), .ce_pixel(ce_pixel), .color_in(color_in),
    .hblank(hblank), .vblank(vblank), .wr(wr), .address(address), .din(din),
    .dout(dout), .red(red), .green(green), .blue(blue),
    .hblank_out(hblank_out), .vblank_out(vblank_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] c;
    logic       hb, vb;
    logic [7:0] r, g, b;
    logic       hbo, vbo;
  } vvec_t;

  typedef struct {
    logic [8:0]  a;
    logic [15:0] d;
  } rvec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [8:0] a, input logic [15:0] d, input logic [1:0] w);
    address = a; din = d; wr = w;
    step();
    wr = 2'b00;
  endtask

  task automatic cpu_rd(input string nm, input logic [8:0] a, input logic [15:0] exp);
    address = a;
    step();
    chk(nm, {16'd0, dout}, {16'd0, exp});
  endtask

  task automatic pix(input logic [7:0] c, input logic hb, input logic vb);
    color_in = c; hblank = hb; vblank = vb; ce_pixel = 1'b1;
    step();
    ce_pixel = 1'b0;
  endtask

  task automatic chk_vid(input string nm, input logic [7:0] r, input logic [7:0] g,
                         input logic [7:0] b, input logic hbo, input logic vbo);
    chk(nm, {6'd0, red, green, blue, hblank_out, vblank_out}, {6'd0, r, g, b, hbo, vbo});
  endtask

  vvec_t vt[13];
  rvec_t rt[7];

  initial begin
    vt[0]  = '{8'h25, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vt[1]  = '{8'hFF, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0};
    vt[2]  = '{8'h01, 1'b1, 1'b0, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0};
    vt[3]  = '{8'h02, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
    vt[4]  = '{8'h03, 1'b0, 1'b1, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0};
    vt[5]  = '{8'h10, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
    vt[6]  = '{8'h25, 1'b0, 1'b0, 8'h84, 8'h84, 8'h84, 1'b0, 1'b0};
    vt[7]  = '{8'h00, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0};
    vt[8]  = '{8'h03, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vt[9]  = '{8'h03, 1'b0, 1'b0, 8'h08, 8'h08, 8'h08, 1'b0, 1'b0};
    vt[10] = '{8'h10, 1'b0, 1'b1, 8'h08, 8'h08, 8'h08, 1'b0, 1'b0};
    vt[11] = '{8'h10, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
    vt[12] = '{8'h00, 1'b0, 1'b0, 8'h84, 8'h84, 8'h84, 1'b0, 1'b0};

    rt[0] = '{9'h025, 16'h7FFF};
    rt[1] = '{9'h010, 16'h4210};
    rt[2] = '{9'h0FF, 16'h001F};
    rt[3] = '{9'h003, 16'h8421};
    rt[4] = '{9'h001, 16'h7C00};
    rt[5] = '{9'h100, CTRL_RESET};
    rt[6] = '{9'h000, 16'h0000};

    step(); step();
    chk_vid("reset_video", 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
    chk("reset_dout", {16'd0, dout}, 32'd0);
    reset_n = 1'b1;
    step();

    cpu_wr(9'h025, 16'h7FFF, 2'b11);
    cpu_wr(9'h010, 16'h4210, 2'b11);
    cpu_wr(9'h000, 16'h0000, 2'b11);
    cpu_wr(9'h0FF, 16'h001F, 2'b11);
    cpu_wr(9'h001, 16'h7C00, 2'b11);
    cpu_wr(9'h002, 16'h03E0, 2'b11);
    cpu_wr(9'h003, 16'h8421, 2'b11);
    cpu_wr(9'h100, 16'h7FFF, 2'b11);

    for (int i = 0; i < 7; i++) cpu_rd($sformatf("rd%0d", i), rt[i].a, rt[i].d);

    pix(8'h00, 1'b0, 1'b0);
    pix(8'h00, 1'b0, 1'b0);
    chk_vid("prime", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) begin
      pix(vt[i].c, vt[i].hb, vt[i].vb);
      chk_vid($sformatf("vid%0d", i), vt[i].r, vt[i].g, vt[i].b, vt[i].hbo, vt[i].vbo);
    end

    cpu_wr(9'h025, 16'h001F, 2'b01);
    cpu_rd("lowlane_rd", 9'h025, 16'h7F1F);
    pix(8'h25, 1'b0, 1'b0);
    pix(8'h25, 1'b0, 1'b0);
    chk_vid("lowlane_vid", 8'hFF, 8'hC6, 8'hFF, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      color_in = 8'(i * 17); hblank = i[0]; vblank = i[1];
      address = 9'(i);
      step();
      chk_vid($sformatf("hold%0d", i), 8'hFF, 8'hC6, 8'hFF, 1'b0, 1'b0);
    end

    cpu_wr(9'h002, 16'hAB00, 2'b10);
    cpu_rd("highlane_rd", 9'h002, 16'hABE0);

    cpu_wr(9'h040, 16'h7C00, 2'b11);
    pix(8'h40, 1'b0, 1'b0);
    address = 9'h040; din = 16'h001F; wr = 2'b11;
    color_in = 8'h40; ce_pixel = 1'b1;
    step();
    wr = 2'b00; ce_pixel = 1'b0;
    chk_vid("rdw_old", 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0);
    pix(8'h40, 1'b0, 1'b0);
    chk_vid("rdw_new", 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0);

`ifdef PALETTE_FADE_EN
    cpu_wr(9'h030, 16'h7FFF, 2'b11);
    cpu_wr(9'h100, 16'h0008, 2'b01);
    cpu_rd("bright8_rd", 9'h100, 16'h0008);
    pix(8'h30, 1'b0, 1'b0);
    pix(8'h30, 1'b0, 1'b0);
    chk_vid("fade8", 8'h7F, 8'h7F, 8'h7F, 1'b0, 1'b0);
    cpu_wr(9'h100, 16'h001F, 2'b01);
    cpu_rd("bright31_rd", 9'h100, 16'h0010);
    pix(8'h30, 1'b0, 1'b0);
    chk_vid("fade16", 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
`endif

    pix(8'h25, 1'b0, 1'b0);
    pix(8'h25, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_vid("async_reset", 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
    step();
    reset_n = 1'b1;
    step();
    pix(8'h25, 1'b0, 1'b0);
    chk("post_reset_1", {24'd0, red}, 32'd0);
    pix(8'h25, 1'b0, 1'b0);
    chk_vid("post_reset_2", 8'hFF, 8'hC6, 8'hFF, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
